select_pulse_decoder: RTL and testbench

Parametrised, multi-channel, registered successor to the dual 2:4 decoder. Each channel accepts a select code through a req/ready handshake and latches it. It then drives exactly one active-low output low for a fixed number of cycles, followed by a mandatory all-high recovery gap. The block sits between bus/control sequencing logic and the chip-select or strobe lines of the TTL-modelled datapath, and replaces hand-timed decoder enables.

---
 rtl/select_pulse_decoder_pkg.sv | 17 +
 rtl/select_pulse_decoder_channel.sv | 82 ++++++++
 rtl/select_pulse_decoder.sv | 39 +++
 tb/tb_select_pulse_decoder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/select_pulse_decoder_pkg.sv
// Shared types and helpers for the select pulse decoder.
package select_pulse_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // Width of a down-counter able to hold max(pulse, gap) cycles.
  function automatic int unsigned cnt_width(input int pulse_cycles, input int gap_cycles);
    int m;
    m = (pulse_cycles > gap_cycles) ? pulse_cycles : gap_cycles;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/select_pulse_decoder_channel.sv
// One decoder channel: handshake, latched code, pulse/gap timing, decode and mask.
module select_pulse_channel
  import select_pulse_pkg::*;
#(
  parameter int SEL_WIDTH    = 2,
  parameter int PULSE_CYCLES = 1,
  parameter int GAP_CYCLES   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable_n,
  input  logic                       req,
  input  logic [SEL_WIDTH-1:0]       sel,
  output logic                       ready,
  output logic [0:(2**SEL_WIDTH)-1]  out_n,
  output logic                       done
);

  localparam int OUTS       = 2**SEL_WIDTH;
  localparam int CW         = cnt_width(PULSE_CYCLES, GAP_CYCLES);
  localparam int GAP_LOAD_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_LOAD_I);

  if (PULSE_CYCLES < 1 || GAP_CYCLES < 0) begin : g_param_check
    $error("select_pulse_channel: PULSE_CYCLES must be >= 1 and GAP_CYCLES >= 0");
  end

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [SEL_WIDTH-1:0] code;
  logic [0:OUTS-1]      dec_n;

  // Counter holds remaining cycles minus one; zero is the terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      code  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req) begin
            state <= S_PULSE;
            cnt   <= PULSE_LOAD;
            code  <= sel;
          end
        end
        S_PULSE: begin
          if (cnt == '0) begin
            done <= 1'b1;
            if (GAP_CYCLES == 0) begin
              state <= S_IDLE;
            end else begin
              state <= S_GAP;
              cnt   <= GAP_LOAD;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == '0) state <= S_IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Decode from registered state and code only, so sel cannot glitch the outputs.
  always_comb begin
    dec_n = '1;
    if (state == S_PULSE) dec_n[code] = 1'b0;
  end

  assign ready = (state == S_IDLE);
  assign out_n = dec_n | {OUTS{enable_n}};

endmodule

// File: rtl/select_pulse_decoder.sv
// Multi-channel registered select pulse decoder; channels are independent.
module select_pulse_decoder
  import select_pulse_pkg::*;
#(
  parameter int SEL_WIDTH    = 2,
  parameter int CHANNELS     = 2,
  parameter int PULSE_CYCLES = 1,
  parameter int GAP_CYCLES   = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [CHANNELS-1:0]                   enable_n,
  input  logic [CHANNELS-1:0]                   req,
  output logic [CHANNELS-1:0]                   ready,
  input  logic [CHANNELS*SEL_WIDTH-1:0]         sel,
  output logic [0:CHANNELS*(2**SEL_WIDTH)-1]    out_n,
  output logic [CHANNELS-1:0]                   done
);

  localparam int OUTS = 2**SEL_WIDTH;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    select_pulse_channel #(
      .SEL_WIDTH   (SEL_WIDTH),
      .PULSE_CYCLES(PULSE_CYCLES),
      .GAP_CYCLES  (GAP_CYCLES)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .enable_n(enable_n[c]),
      .req     (req[c]),
      .sel     (sel[c*SEL_WIDTH +: SEL_WIDTH]),
      .ready   (ready[c]),
      .out_n   (out_n[c*OUTS +: OUTS]),
      .done    (done[c])
    );
  end

endmodule

// File: tb/tb_select_pulse_decoder.sv
// Self-checking bench for select_pulse_decoder across several parameter sets.
module tb_select_pulse_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic rst;
  logic p4_rst;

  // Default parameters
  logic [1:0] d_en_n, d_req, d_ready, d_done;
  logic [3:0] d_sel;
  logic [0:7] d_out_n;

  // PULSE_CYCLES=3, GAP_CYCLES=0
  logic [1:0] p3_en_n, p3_req, p3_ready, p3_done;
  logic [3:0] p3_sel;
  logic [0:7] p3_out_n;

  // PULSE_CYCLES=4, GAP_CYCLES=1
  logic [1:0] p4_en_n, p4_req, p4_ready, p4_done;
  logic [3:0] p4_sel;
  logic [0:7] p4_out_n;

  // SEL_WIDTH=3, CHANNELS=4
  logic [3:0]  w3_en_n, w3_req, w3_ready, w3_done;
  logic [11:0] w3_sel;
  logic [0:31] w3_out_n;

  select_pulse_decoder u_def (
    .clk(clk), .rst(rst), .enable_n(d_en_n), .req(d_req), .ready(d_ready),
    .sel(d_sel), .out_n(d_out_n), .done(d_done)
  );

  select_pulse_decoder #(.PULSE_CYCLES(3), .GAP_CYCLES(0)) u_p3 (
    .clk(clk), .rst(rst), .enable_n(p3_en_n), .req(p3_req), .ready(p3_ready),
    .sel(p3_sel), .out_n(p3_out_n), .done(p3_done)
  );

  select_pulse_decoder #(.PULSE_CYCLES(4), .GAP_CYCLES(1)) u_p4 (
    .clk(clk), .rst(p4_rst), .enable_n(p4_en_n), .req(p4_req), .ready(p4_ready),
    .sel(p4_sel), .out_n(p4_out_n), .done(p4_done)
  );

  select_pulse_decoder #(.SEL_WIDTH(3), .CHANNELS(4)) u_w3 (
    .clk(clk), .rst(rst), .enable_n(w3_en_n), .req(w3_req), .ready(w3_ready),
    .sel(w3_sel), .out_n(w3_out_n), .done(w3_done)
  );

  typedef struct {
    logic [1:0] req;
    logic [3:0] sel;
    logic [1:0] en_n;
    logic [1:0] ready;
    logic [7:0] out_n;
    logic [1:0] done;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  e_p3_out[8];
  logic        e_p3_flag[8];
  logic [0:31] e_w3;

  initial begin
    // Reset held two cycles with every request asserted.
    rst = 1'b1; p4_rst = 1'b1;
    d_en_n = '0;  d_req = '1;  d_sel = '0;
    p3_en_n = '0; p3_req = '1; p3_sel = '0;
    p4_en_n = '0; p4_req = '1; p4_sel = '0;
    w3_en_n = '0; w3_req = '1; w3_sel = '0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("rst%0d d_ready", i), 32'(d_ready), 32'h3);
      chk($sformatf("rst%0d d_out_n", i), 32'(d_out_n), 32'hFF);
      chk($sformatf("rst%0d d_done", i), 32'(d_done), 32'h0);
      chk($sformatf("rst%0d w3_out_n", i), 32'(w3_out_n), 32'hFFFF_FFFF);
      chk($sformatf("rst%0d p4_ready", i), 32'(p4_ready), 32'h3);
    end
    rst = 1'b0; p4_rst = 1'b0;
    d_req = '0; p3_req = '0; p4_req = '0; w3_req = '0;

    // Default-parameter vectors: inputs applied, then outputs after the edge.
    vecs[0]  = '{2'b00, 4'b0000, 2'b00, 2'b11, 8'hFF, 2'b00}; // no pulse after reset
    vecs[1]  = '{2'b01, 4'b0010, 2'b00, 2'b10, 8'hDF, 2'b00}; // ch0 code 2
    vecs[2]  = '{2'b00, 4'b0000, 2'b00, 2'b10, 8'hFF, 2'b01}; // gap + done
    vecs[3]  = '{2'b00, 4'b0000, 2'b00, 2'b11, 8'hFF, 2'b00}; // ready back
    vecs[4]  = '{2'b10, 4'b1100, 2'b10, 2'b01, 8'hFF, 2'b00}; // ch1 masked
    vecs[5]  = '{2'b00, 4'b0000, 2'b10, 2'b01, 8'hFF, 2'b10}; // masked done
    vecs[6]  = '{2'b00, 4'b0000, 2'b00, 2'b11, 8'hFF, 2'b00};
    vecs[7]  = '{2'b10, 4'b0000, 2'b00, 2'b01, 8'hF7, 2'b00}; // ch1 code 0
    vecs[8]  = '{2'b11, 4'b0001, 2'b00, 2'b00, 8'hBF, 2'b10}; // ch1 req ignored
    vecs[9]  = '{2'b00, 4'b0000, 2'b00, 2'b10, 8'hFF, 2'b01};
    vecs[10] = '{2'b00, 4'b0000, 2'b00, 2'b11, 8'hFF, 2'b00};
    for (int i = 0; i < 11; i++) begin
      d_req = vecs[i].req; d_sel = vecs[i].sel; d_en_n = vecs[i].en_n;
      step();
      chk($sformatf("vec%0d ready", i), 32'(d_ready), 32'(vecs[i].ready));
      chk($sformatf("vec%0d out_n", i), 32'(d_out_n), 32'(vecs[i].out_n));
      chk($sformatf("vec%0d done", i), 32'(d_done), 32'(vecs[i].done));
    end
    d_req = '0; d_en_n = '0;

    // Back-to-back pulses with req held; sel change mid-pulse has no effect.
    e_p3_out  = '{4'b0111, 4'b0111, 4'b0111, 4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1111};
    e_p3_flag = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    p3_req = 2'b01; p3_sel = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) p3_sel = 4'b0011;
      chk($sformatf("p3 c%0d out_n", i), 32'(p3_out_n[0:3]), 32'(e_p3_out[i]));
      chk($sformatf("p3 c%0d done", i), 32'(p3_done[0]), 32'(e_p3_flag[i]));
      chk($sformatf("p3 c%0d ready", i), 32'(p3_ready[0]), 32'(e_p3_flag[i]));
      chk($sformatf("p3 c%0d ch1", i), 32'(p3_out_n[4:7]), 32'hF);
    end
    p3_req = '0;

    // Reset during the second cycle of a 4-cycle pulse, with req still high.
    p4_req = 2'b01; p4_sel = 4'b0001;
    step();
    chk("p4 pulse1 out_n", 32'(p4_out_n), 32'hBF);
    step();
    chk("p4 pulse2 out_n", 32'(p4_out_n), 32'hBF);
    p4_rst = 1'b1;
    step();
    chk("p4 rst out_n", 32'(p4_out_n), 32'hFF);
    chk("p4 rst done", 32'(p4_done), 32'h0);
    chk("p4 rst ready", 32'(p4_ready), 32'h3);
    p4_rst = 1'b0; p4_req = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("p4 post%0d out_n", i), 32'(p4_out_n), 32'hFF);
      chk($sformatf("p4 post%0d done", i), 32'(p4_done), 32'h0);
      chk($sformatf("p4 post%0d ready", i), 32'(p4_ready), 32'h3);
    end

    // Four channels accepting together with codes 7,0,5,2.
    w3_sel = {3'd2, 3'd5, 3'd0, 3'd7};
    w3_req = 4'hF;
    e_w3 = '1;
    e_w3[7] = 1'b0; e_w3[8] = 1'b0; e_w3[21] = 1'b0; e_w3[26] = 1'b0;
    step();
    w3_req = '0;
    chk("w3 pulse out_n", 32'(w3_out_n), 32'(e_w3));
    chk("w3 pulse ready", 32'(w3_ready), 32'h0);
    step();
    chk("w3 gap out_n", 32'(w3_out_n), 32'hFFFF_FFFF);
    chk("w3 gap done", 32'(w3_done), 32'hF);
    step();
    chk("w3 idle ready", 32'(w3_ready), 32'hF);
    chk("w3 idle done", 32'(w3_done), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
